// File: rtl/ctrl_lut_pipe.sv
// Runtime-programmable control lookup table with one registered valid/ready stage.
// Unprogrammed entries decode to NOP with miss set, and a saturating counter tallies them.
module ctrl_lut_pipe #(
    parameter int unsigned OP_W       = 9,
    parameter int unsigned ALU_OP_W   = 5,
    parameter int unsigned RADDR_W    = 4,
    parameter int unsigned PC_W       = 16,
    parameter int unsigned IMM_W      = 8,
    parameter int unsigned MISS_CNT_W = 8,
    localparam int unsigned ENTRY_W   = 3 + ALU_OP_W + 3*RADDR_W + PC_W + IMM_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [OP_W-1:0]       cfg_addr,
    input  logic [ENTRY_W-1:0]    cfg_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_W-1:0]       op_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  mem_w,
    output logic                  rf_w,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic [RADDR_W-1:0]    rs_addr,
    output logic [RADDR_W-1:0]    rt_addr,
    output logic [RADDR_W-1:0]    rd_addr,
    output logic [PC_W-1:0]       imm_pc,
    output logic [IMM_W-1:0]      alu_in,
    output logic                  alu_sel,
    output logic                  miss,
    output logic [MISS_CNT_W-1:0] miss_cnt
);

    localparam int unsigned DEPTH = 1 << OP_W;

    logic [ENTRY_W-1:0] table_mem [DEPTH];
    logic [DEPTH-1:0]   prog;

    logic [ENTRY_W-1:0] out_word;
    logic [ENTRY_W-1:0] dec_word;
    logic               dec_miss;
    logic               fwd_hit;
    logic               accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Write-first forwarding: a same-cycle write to the looked-up index wins.
    always_comb begin
        dec_word = '0;
        dec_miss = 1'b1;
        fwd_hit  = cfg_we && (cfg_addr == op_i);
        if (fwd_hit) begin
            dec_word = cfg_data;
            dec_miss = 1'b0;
        end else if (prog[op_i]) begin
            dec_word = table_mem[op_i];
            dec_miss = 1'b0;
        end
    end

    // Table data carries no reset; only the programmed flags are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && cfg_we) begin
            table_mem[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prog <= '0;
        end else if (cfg_we) begin
            prog[cfg_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            miss      <= 1'b0;
            miss_cnt  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_word  <= dec_word;
            miss      <= dec_miss;
            if (dec_miss && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign {mem_w, rf_w, alu_op, rs_addr, rt_addr, rd_addr, imm_pc, alu_in, alu_sel} = out_word;

endmodule

// File: doc/ctrl_lut_pipe.md
Name: ctrl_lut_pipe

Overview:
Parametrised, runtime-programmable successor to the combinational control lookup table. Maps an OP_W-bit instruction index to a packed control word: mem write, regfile write, ALU op, rs/rt/rd, branch immediate, ALU constant and ALU-source select. Table contents are loaded through a config write port instead of being hard-coded. One registered pipeline stage with valid/ready handshake sits between fetch and the datapath. Unprogrammed entries decode to a safe NOP and are counted.

Parameters:
OP_W, 9, instruction index width; table depth = 2**OP_W
ALU_OP_W, 5, alu_op field width
RADDR_W, 4, register pointer width (rs/rt/rd)
PC_W, 16, imm_pc width
IMM_W, 8, alu_in width
MISS_CNT_W, 8, saturating miss counter width
ENTRY_W, 3+ALU_OP_W+3*RADDR_W+PC_W+IMM_W (44 default), packed entry width (derived, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  OP_W  table write index
cfg_data  in  ENTRY_W  packed entry, MSB..LSB: mem_w, rf_w, alu_op, rs_addr, rt_addr, rd_addr, imm_pc, alu_in, alu_sel
in_valid  in  1  op_i valid
in_ready  out  1  stage can accept op_i
op_i  in  OP_W  instruction index
out_valid  out  1  decoded word valid
out_ready  in  1  downstream accepts word
mem_w  out  1  memory write enable
rf_w  out  1  register file write enable
alu_op  out  ALU_OP_W  ALU operation
rs_addr  out  RADDR_W  source pointer 1
rt_addr  out  RADDR_W  source pointer 2
rd_addr  out  RADDR_W  destination pointer
imm_pc  out  PC_W  branch/jump immediate
alu_in  out  IMM_W  ALU constant
alu_sel  out  1  1 = ALU B from alu_in, 0 = from register
miss  out  1  current word came from an unprogrammed entry
miss_cnt  out  MISS_CNT_W  saturating count of accepted misses

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0; all decoded outputs, miss and miss_cnt = 0; every entry's programmed flag cleared (table data need not be cleared). cfg_we and in_valid are ignored during a reset cycle. Reset mid-transfer drops the held word.
- Table write: on posedge with cfg_we=1, entry[cfg_addr] <= cfg_data and its programmed flag is set. Rewriting an entry overwrites it.
- in_ready = !out_valid || out_ready (combinational; no dependency on in_valid).
- Accept = in_valid && in_ready. On accept at posedge, the output register loads the decode of op_i and out_valid <= 1. Latency is 1 cycle, input accept to out_valid.
- If out_valid && out_ready && !in_valid, then out_valid <= 0. Outputs keep their last values; their contents are don't-care when out_valid=0.
- Hold: while out_valid && !out_ready, all outputs stay stable and in_ready=0.
- Full throughput: with out_ready held at 1, one word per cycle.
- Write/lookup collision: if cfg_we && accept && cfg_addr==op_i in the same cycle, the decode uses cfg_data and miss=0 (write-first forwarding).
- Miss: on accept of an unprogrammed entry (and no forwarding hit), the outputs load NOP: all fields 0 and miss=1. On the same edge, miss_cnt increments and saturates at 2**MISS_CNT_W-1. Only accepted lookups count.
- Table writes are independent of the handshake and never stall it. A write does not alter a word already held in the output register.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, miss_cnt=0; after op_i=0x000 is accepted with no table writes -> next cycle out_valid=1, miss=1, all fields 0, miss_cnt=1.
- Write entry 0x001 = {mem_w=0, rf_w=0, alu_op=01100, rs=0, rt=0, rd=1, imm_pc=0, alu_in=0x80, alu_sel=1}, then look up 0x001 -> one cycle later alu_op=0x0C, rd_addr=1, alu_in=0x80, alu_sel=1, miss=0.
- Back-to-back ops 0x001, 0x002 with out_ready=0 for 3 cycles -> first word held stable, in_ready=0, op 0x002 is not taken until out_ready=1; then both words appear in order.
- Same cycle: cfg_we with cfg_addr=0x005, alu_in=0xFF, while op_i=0x005 is accepted -> output alu_in=0xFF, miss=0.
- 300 accepted lookups of an unprogrammed index -> miss_cnt saturates at 255 and does not wrap.
- Program entries, fill the pipe, assert rst_n=0 for one cycle -> out_valid=0, miss_cnt=0; a lookup of a previously programmed index then returns miss=1.
